// File: rtl/sm_arith_if.sv
// Handshake bundle for sm_arith_pipe: operand input side and result output side.
// The block (slave) consumes operands and produces results. The driver/checker is the master.
interface sm_arith_if #(
  parameter int unsigned W = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o;
  logic         flag;
  logic [W-1:0] acc;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, o, flag, acc
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, o, flag, acc
  );
endinterface

// File: rtl/sm_arith_pipe.sv
// Two-stage pipelined sign-magnitude ADD/SUB/ACC/CLR unit with valid/ready on both sides.
// Define SM_SATURATE_EN to saturate on overflow; the default build wraps.
module sm_arith_pipe #(
  parameter int unsigned W = 3
) (
  input logic        clk,
  input logic        rst,
  sm_arith_if.slave  bus
);

  localparam int unsigned M = W - 1;

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAcc = 2'b10,
    OpClr = 2'b11
  } op_e;

  // Returns {overflow, sign, magnitude}. neg_y flips y's sign so SUB reuses the adder.
  function automatic logic [W:0] sm_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic neg_y);
    logic         sx, sy, sr, ov;
    logic [M-1:0] mx, my, mr;
    logic [M:0]   sum;
    mx  = x[M-1:0];
    my  = y[M-1:0];
    sx  = x[W-1] & (mx != '0);
    sy  = (y[W-1] & (my != '0)) ^ neg_y;
    sum = '0;
    ov  = 1'b0;
    if (sx == sy) begin
      sum = {1'b0, mx} + {1'b0, my};
      sr  = sx;
      ov  = sum[M];
      mr  = sum[M-1:0];
`ifdef SM_SATURATE_EN
      if (ov) begin
        mr = '1;
      end
`endif
    end else if (mx >= my) begin
      mr = mx - my;
      sr = sx;
    end else begin
      mr = my - mx;
      sr = sy;
    end
    // Never emit negative zero, including a wrapped-to-zero sum.
    if (mr == '0) begin
      sr = 1'b0;
    end
    return {ov, sr, mr};
  endfunction

  logic         s1_valid_q;
  op_e          s1_op_q;
  logic [W-1:0] s1_a_q;
  logic [W-1:0] s1_b_q;

  logic         s2_valid_q;
  logic [W-1:0] o_q;
  logic         flag_q;
  logic [W-1:0] acc_q;

  logic         s2_load;
  logic         in_xfer;
  logic [W:0]   res;
  logic [W-1:0] o_d;
  logic         flag_d;
  logic [W-1:0] acc_d;

  assign s2_load      = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign bus.in_ready = ~rst & (~s1_valid_q | s2_load);
  assign in_xfer      = bus.in_valid & bus.in_ready;

  // acc_q is read here at S2-load time, so back-to-back ACC ops chain.
  always_comb begin
    res   = '0;
    acc_d = acc_q;
    unique case (s1_op_q)
      OpAdd:   res = sm_add(s1_a_q, s1_b_q, 1'b0);
      OpSub:   res = sm_add(s1_a_q, s1_b_q, 1'b1);
      OpAcc:   res = sm_add(acc_q, s1_a_q, 1'b0);
      OpClr:   res = '0;
      default: res = '0;
    endcase
    o_d    = res[W-1:0];
    flag_d = res[W];
    if (s1_op_q == OpAcc || s1_op_q == OpClr) begin
      acc_d = o_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpAdd;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= op_e'(bus.op);
      s1_a_q     <= bus.a;
      s1_b_q     <= bus.b;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      o_q        <= '0;
      flag_q     <= 1'b0;
      acc_q      <= '0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      o_q        <= o_d;
      flag_q     <= flag_d;
      acc_q      <= acc_d;
    end else if (bus.out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.o         = o_q;
  assign bus.flag      = flag_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_sm_arith_pipe.sv
// Directed bench for sm_arith_pipe at W=4; expectations follow SM_SATURATE_EN when defined.
module tb_sm_arith_pipe;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic       f;
    logic [3:0] acc;
  } vec_t;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic clk;
  logic rst;
  sm_arith_if #(.W(4)) bus ();

  sm_arith_pipe #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       s_ix, s_ox, s_ir, s_ov, s_f;
  logic [3:0] s_o, s_acc;

  vec_t tv[17];
  vec_t sv[8];

  function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] o, input logic f, input logic [3:0] acc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.o = o; v.f = f; v.acc = acc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sample just after the negedge-aligned drive, then advance one full cycle.
  task automatic step();
    #1;
    s_ix  = bus.in_valid & bus.in_ready;
    s_ox  = bus.out_valid & bus.out_ready;
    s_ir  = bus.in_ready;
    s_ov  = bus.out_valid;
    s_o   = bus.o;
    s_f   = bus.flag;
    s_acc = bus.acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall,
                            output int cyc, output int rcv);
    int idx;
    idx = 0;
    rcv = 0;
    cyc = 0;
    while (rcv < n && cyc < 60) begin
      bus.out_ready = (cyc >= stall);
      bus.in_valid  = (idx < n);
      if (idx < n) begin
        bus.op = sv[idx].op;
        bus.a  = sv[idx].a;
        bus.b  = sv[idx].b;
      end
      step();
      if (s_ix) idx++;
      if (s_ox) begin
        check($sformatf("%s r%0d o", tag, rcv), 32'(s_o), 32'(sv[rcv].o));
        check($sformatf("%s r%0d flag", tag, rcv), 32'(s_f), 32'(sv[rcv].f));
        check($sformatf("%s r%0d acc", tag, rcv), 32'(s_acc), 32'(sv[rcv].acc));
        rcv++;
      end
      if (stall >= 4 && cyc == stall - 1) begin
        check({tag, " accepts while stalled"}, idx, 2);
        check({tag, " in_ready while full"}, 32'(s_ir), 0);
        check({tag, " out_valid held"}, 32'(s_ov), 1);
        check({tag, " o held"}, 32'(s_o), 32'(sv[0].o));
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, " results received"}, rcv, n);
  endtask

  initial begin
    int edges, tries, cyc, rcv;

    tv[0]  = mk(ADD, 4'b0011, 4'b1101, 4'b1010, 1'b0, 4'b0000);
`ifdef SM_SATURATE_EN
    tv[1]  = mk(ADD, 4'b0110, 4'b0101, 4'b0111, 1'b1, 4'b0000);
`else
    tv[1]  = mk(ADD, 4'b0110, 4'b0101, 4'b0011, 1'b1, 4'b0000);
`endif
    tv[2]  = mk(SUB, 4'b1010, 4'b0011, 4'b1101, 1'b0, 4'b0000);
    tv[3]  = mk(ADD, 4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b0000);
    tv[4]  = mk(ADD, 4'b0100, 4'b1100, 4'b0000, 1'b0, 4'b0000);
    tv[5]  = mk(SUB, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
`ifdef SM_SATURATE_EN
    tv[6]  = mk(ADD, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0000);
    tv[7]  = mk(SUB, 4'b0111, 4'b1001, 4'b0111, 1'b1, 4'b0000);
`else
    tv[6]  = mk(ADD, 4'b1111, 4'b1111, 4'b1110, 1'b1, 4'b0000);
    tv[7]  = mk(SUB, 4'b0111, 4'b1001, 4'b0000, 1'b1, 4'b0000);
`endif
    tv[8]  = mk(ADD, 4'b0010, 4'b1111, 4'b1101, 1'b0, 4'b0000);
    tv[9]  = mk(CLR, 4'b0101, 4'b0110, 4'b0000, 1'b0, 4'b0000);
    tv[10] = mk(ACC, 4'b0101, 4'b1111, 4'b0101, 1'b0, 4'b0101);
    tv[11] = mk(ACC, 4'b0001, 4'b0111, 4'b0110, 1'b0, 4'b0110);
    tv[12] = mk(ACC, 4'b1011, 4'b0000, 4'b0011, 1'b0, 4'b0011);
`ifdef SM_SATURATE_EN
    tv[13] = mk(ACC, 4'b0110, 4'b1010, 4'b0111, 1'b1, 4'b0111);
    tv[14] = mk(ACC, 4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b0000);
    tv[15] = mk(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 4'b0000);
`else
    tv[13] = mk(ACC, 4'b0110, 4'b1010, 4'b0001, 1'b1, 4'b0001);
    tv[14] = mk(ACC, 4'b1111, 4'b0001, 4'b1110, 1'b0, 4'b1110);
    tv[15] = mk(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 4'b1110);
`endif
    tv[16] = mk(CLR, 4'b0111, 4'b0111, 4'b0000, 1'b0, 4'b0000);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = ADD;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset in_ready", 32'(bus.in_ready), 0);
    check("reset o", 32'(bus.o), 0);
    check("reset flag", 32'(bus.flag), 0);
    check("reset acc", 32'(bus.acc), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single ops: accept, then the result must be visible exactly two edges later.
    for (int i = 0; i < 17; i++) begin
      bus.op       = tv[i].op;
      bus.a        = tv[i].a;
      bus.b        = tv[i].b;
      bus.in_valid = 1'b1;
      tries = 0;
      do begin
        step();
        tries++;
      end while (!s_ix && tries < 20);
      check($sformatf("v%0d accepted", i), 32'(s_ix), 1);
      bus.in_valid = 1'b0;
      edges = 1;
      step();
      while (!s_ox && edges < 20) begin
        edges++;
        step();
      end
      check($sformatf("v%0d latency", i), edges, 2);
      check($sformatf("v%0d o", i), 32'(s_o), 32'(tv[i].o));
      check($sformatf("v%0d flag", i), 32'(s_f), 32'(tv[i].f));
      check($sformatf("v%0d acc", i), 32'(s_acc), 32'(tv[i].acc));
    end

    // Back-to-back accumulate chain at full throughput.
    sv[0] = mk(CLR, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    sv[1] = mk(ACC, 4'b0101, 4'b1001, 4'b0101, 1'b0, 4'b0101);
    sv[2] = mk(ACC, 4'b0001, 4'b0000, 4'b0110, 1'b0, 4'b0110);
    sv[3] = mk(ACC, 4'b1011, 4'b0011, 4'b0011, 1'b0, 4'b0011);
`ifdef SM_SATURATE_EN
    sv[4] = mk(ACC, 4'b0110, 4'b0000, 4'b0111, 1'b1, 4'b0111);
`else
    sv[4] = mk(ACC, 4'b0110, 4'b0000, 4'b0001, 1'b1, 4'b0001);
`endif
    sv[5] = mk(CLR, 4'b0011, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    run_stream("chain", 6, 0, cyc, rcv);
    check("chain cycles", cyc, 8);

    // Stalled consumer: fills two deep, then drains in order.
    sv[0] = mk(ADD, 4'b0001, 4'b0001, 4'b0010, 1'b0, 4'b0000);
    sv[1] = mk(ADD, 4'b0010, 4'b0001, 4'b0011, 1'b0, 4'b0000);
    sv[2] = mk(SUB, 4'b0011, 4'b1001, 4'b0100, 1'b0, 4'b0000);
    run_stream("stall", 3, 6, cyc, rcv);
    step();
    check("stall drained out_valid", 32'(s_ov), 0);
    step();
    check("stall no duplicate", 32'(s_ov), 0);

    // Reset with both stages full and acc=+5.
    sv[0] = mk(CLR, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    sv[1] = mk(ACC, 4'b0101, 4'b0000, 4'b0101, 1'b0, 4'b0101);
    run_stream("preload", 2, 0, cyc, rcv);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op = ADD; bus.a = 4'b0001; bus.b = 4'b0001;
    step();
    bus.op = ADD; bus.a = 4'b0010; bus.b = 4'b0010;
    step();
    bus.in_valid = 1'b0;
    step();
    check("full before rst out_valid", 32'(s_ov), 1);
    check("full before rst in_ready", 32'(s_ir), 0);
    check("full before rst acc", 32'(s_acc), 32'(4'b0101));
    #2 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 0);
    check("async rst acc", 32'(bus.acc), 0);
    check("async rst o", 32'(bus.o), 0);
    check("async rst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    sv[0] = mk(ADD, 4'b0011, 4'b0001, 4'b0100, 1'b0, 4'b0000);
    run_stream("post rst", 1, 0, cyc, rcv);
    check("post rst cycles", cyc, 3);
    step();
    check("post rst idle", 32'(s_ov), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
